// File: rtl/note_hit_judge_if.sv
// rtl/note_hit_judge_if.sv - note/pad inputs and judge result outputs of the hit judge
interface note_hit_judge_if #(
    parameter int SCORE_W = 10
);
    logic               note_valid;
    logic [3:0]         note;
    logic [3:0]         pads;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [3:0]         streak;
    logic [3:0]         active;
    logic               full;

    modport master (
        output note_valid, note, pads,
        input  hit, miss, score, streak, active, full
    );

    modport slave (
        input  note_valid, note, pads,
        output hit, miss, score, streak, active, full
    );
endinterface

// File: rtl/note_hit_judge.sv
// rtl/note_hit_judge.sv - queues drum notes and judges pad presses against the oldest one
module note_hit_judge #(
    parameter int WINDOW  = 8,
    parameter int DEPTH   = 4,
    parameter int SCORE_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    note_hit_judge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [3:0]    pads_q, rise, acc, acc_n, active_q, streak_q;
    logic [CW-1:0] win_cnt;
    logic [SCORE_W-1:0] score_q;
    logic          hit_q, miss_q;
    logic          empty, full, push, drop, pop;
    logic          judge_hit, judge_miss;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.note_valid && (bus.note != 4'b0000) && !full;
    assign drop  = bus.note_valid && (bus.note != 4'b0000) && full;
    assign rise  = bus.pads & ~pads_q;
    assign pop   = judge_hit || judge_miss;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Wrong pad beats a completed chord, which beats the window running out.
    always_comb begin
        state_n    = state;
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        acc_n      = acc | rise;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = ACTIVE;
            end
            ACTIVE: begin
                if ((acc_n & ~active_q) != 4'b0000) begin
                    judge_miss = 1'b1;
                end else if (acc_n == active_q) begin
                    judge_hit = 1'b1;
                end else if (win_cnt == CW'(1)) begin
                    judge_miss = 1'b1;
                end
                if (judge_hit || judge_miss) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.note;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pads_q   <= 4'b1111;
            acc      <= 4'b0000;
            active_q <= 4'b0000;
            win_cnt  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= '0;
            streak_q <= 4'd0;
        end else begin
            pads_q <= bus.pads;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (state == LOAD) begin
                active_q <= mem[rd_ptr[AW-1:0]];
                acc      <= 4'b0000;
                win_cnt  <= CW'(WINDOW);
            end else if (state == ACTIVE) begin
                acc     <= acc_n;
                win_cnt <= win_cnt - CW'(1);
                if (pop) begin
                    active_q <= 4'b0000;
                end
            end
            hit_q  <= judge_hit;
            miss_q <= (judge_miss || drop) && !judge_hit;
            if (judge_hit && (score_q != SCORE_MAX)) begin
                score_q <= score_q + SCORE_W'(1);
            end
            // A drop in the same cycle as a hit still breaks the streak.
            if (judge_miss || drop) begin
                streak_q <= 4'd0;
            end else if (judge_hit && (streak_q != 4'd15)) begin
                streak_q <= streak_q + 4'd1;
            end
        end
    end

    assign bus.hit    = hit_q;
    assign bus.miss   = miss_q;
    assign bus.score  = score_q;
    assign bus.streak = streak_q;
    assign bus.active = active_q;
    assign bus.full   = full;
endmodule

// File: tb/tb_note_hit_judge.sv
// tb/tb_note_hit_judge.sv - directed table, corner sequences and random run against a note-queue model
module tb_note_hit_judge;
    localparam int WINDOW  = 8;
    localparam int DEPTH   = 4;
    localparam int SCORE_W = 10;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    note_hit_judge_if #(.SCORE_W(SCORE_W)) bus ();

    note_hit_judge #(.WINDOW(WINDOW), .DEPTH(DEPTH), .SCORE_W(SCORE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pending notes as a queue; a note waits one cycle to be
    // picked up, one to be loaded, then collects presses for up to WINDOW cycles.
    logic [3:0] mq[$];
    int         m_phase  = 0;
    logic [3:0] m_act    = 0;
    logic [3:0] m_acc    = 0;
    int         m_used   = 0;
    logic       m_hit    = 0;
    logic       m_miss   = 0;
    int         m_score  = 0;
    int         m_streak = 0;
    logic [3:0] m_prev   = 4'hf;
    logic       m_live   = 0;
    logic [3:0] m_pr, m_dummy;
    logic       m_jh, m_jm, m_dr, m_pu, m_full;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_phase = 0; m_act = 0; m_acc = 0; m_used = 0;
            m_hit = 0; m_miss = 0; m_score = 0; m_streak = 0;
            m_prev = 4'hf; m_live = 1;
        end else begin
            m_pr   = bus.pads & ~m_prev;
            m_prev = bus.pads;
            m_jh = 0; m_jm = 0;
            m_dr = bus.note_valid && (bus.note != 0) && (mq.size() == DEPTH);
            m_pu = bus.note_valid && (bus.note != 0) && (mq.size() < DEPTH);
            case (m_phase)
                0: if (mq.size() > 0) m_phase = 1;
                1: begin m_act = mq[0]; m_acc = 0; m_used = 0; m_phase = 2; end
                default: begin
                    m_acc  = m_acc | m_pr;
                    m_used = m_used + 1;
                    if ((m_acc & ~m_act) != 0) m_jm = 1;
                    else if (m_acc == m_act)   m_jh = 1;
                    else if (m_used == WINDOW) m_jm = 1;
                    if (m_jh || m_jm) begin
                        m_dummy = mq.pop_front();
                        m_phase = 0;
                        m_act   = 0;
                    end
                end
            endcase
            if (m_pu) mq.push_back(bus.note);
            if (m_jh) begin
                if (m_score < 1023) m_score = m_score + 1;
                if (m_streak < 15)  m_streak = m_streak + 1;
            end
            if (m_jm || m_dr) m_streak = 0;
            m_hit  = m_jh;
            m_miss = (m_jm || m_dr) && !m_jh;
        end
        m_full = (mq.size() == DEPTH);
        #1;
        if (m_live) begin
            checks++;
            if (bus.hit !== m_hit || bus.miss !== m_miss || bus.score !== SCORE_W'(m_score) ||
                bus.streak !== 4'(m_streak) || bus.active !== m_act || bus.full !== m_full) begin
                failures++;
                $display("FAIL model t=%0t got hit=%0d miss=%0d score=%0d streak=%0d active=%h full=%0d required hit=%0d miss=%0d score=%0d streak=%0d active=%h full=%0d",
                         $time, bus.hit, bus.miss, bus.score, bus.streak, bus.active, bus.full,
                         m_hit, m_miss, m_score, m_streak, m_act, m_full);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic nv, input logic [3:0] n, input logic [3:0] p);
        bus.note_valid = nv;
        bus.note       = n;
        bus.pads       = p;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] p);
        reset = 1'b1;
        step(1'b0, 4'h0, p);
        step(1'b0, 4'h0, p);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".hit"},    int'(bus.hit),    0);
        chk({name, ".miss"},   int'(bus.miss),   0);
        chk({name, ".score"},  int'(bus.score),  0);
        chk({name, ".streak"}, int'(bus.streak), 0);
        chk({name, ".active"}, int'(bus.active), 0);
        chk({name, ".full"},   int'(bus.full),   0);
    endtask

    typedef struct {
        logic       nv;
        logic [3:0] note;
        logic [3:0] pads;
        logic       hit;
        logic       miss;
        logic [9:0] score;
        logic [3:0] streak;
        logic [3:0] active;
        logic       full;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int misses;
        int hits;
        logic [3:0] nt;
        logic [3:0] pd;

        // hit on pad0 then pad2, then a wrong-pad miss
        vecs[0]  = '{1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 10'd0, 4'd0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 10'd0, 4'd0, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 10'd0, 4'd0, 4'h5, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 10'd0, 4'd0, 4'h5, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 10'd0, 4'd0, 4'h5, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 4'h5, 1'b1, 1'b0, 10'd1, 4'd1, 4'h0, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 10'd1, 4'd1, 4'h0, 1'b0};
        vecs[7]  = '{1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 10'd1, 4'd1, 4'h0, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 10'd1, 4'd1, 4'h0, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 10'd1, 4'd1, 4'h2, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 4'h8, 1'b0, 1'b1, 10'd1, 4'd0, 4'h0, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 10'd1, 4'd0, 4'h0, 1'b0};

        bus.note_valid = 1'b0;
        bus.note       = 4'h0;
        bus.pads       = 4'h0;
        reset          = 1'b1;
        @(negedge clk);
        do_reset(4'h0);
        chk_all_zero("reset");

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].nv, vecs[i].note, vecs[i].pads);
            checks++;
            if (bus.hit !== vecs[i].hit || bus.miss !== vecs[i].miss || bus.score !== vecs[i].score ||
                bus.streak !== vecs[i].streak || bus.active !== vecs[i].active || bus.full !== vecs[i].full) begin
                failures++;
                $display("FAIL vec%0d: got hit=%0d miss=%0d score=%0d streak=%0d active=%h full=%0d required hit=%0d miss=%0d score=%0d streak=%0d active=%h full=%0d",
                         i, bus.hit, bus.miss, bus.score, bus.streak, bus.active, bus.full,
                         vecs[i].hit, vecs[i].miss, vecs[i].score, vecs[i].streak, vecs[i].active, vecs[i].full);
            end
        end

        // timeout lands exactly WINDOW ACTIVE cycles after the load
        step(1'b1, 4'h8, 4'h0);
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'h0);
        chk("timeout.active", int'(bus.active), 8);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'h0, 4'h0);
            n++;
            if (bus.miss) break;
        end
        chk("timeout.cycles", n, WINDOW);
        chk("timeout.active_after", int'(bus.active), 0);
        chk("timeout.full", int'(bus.full), 0);

        // overflow: four fit, the fifth is dropped with a miss
        step(1'b1, 4'h1, 4'h0);
        step(1'b1, 4'h2, 4'h0);
        step(1'b1, 4'h4, 4'h0);
        chk("fill.not_full_at_3", int'(bus.full), 0);
        step(1'b1, 4'h8, 4'h0);
        chk("fill.full_at_4", int'(bus.full), 1);
        step(1'b1, 4'h3, 4'h0);
        chk("fill.drop_miss", int'(bus.miss), 1);
        chk("fill.still_full", int'(bus.full), 1);
        misses = 0;
        hits   = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 4'h0, 4'h0);
            misses += int'(bus.miss);
            hits   += int'(bus.hit);
        end
        chk("fill.remaining_misses", misses, 4);
        chk("fill.hits", hits, 0);
        chk("fill.drained", int'(bus.full), 0);

        // a pad held through reset must be released and re-pressed
        do_reset(4'h2);
        chk_all_zero("held_reset");
        step(1'b1, 4'h2, 4'h2);
        step(1'b0, 4'h0, 4'h2);
        step(1'b0, 4'h0, 4'h2);
        chk("held.active", int'(bus.active), 2);
        step(1'b0, 4'h0, 4'h2);
        chk("held.no_hit_held", int'(bus.hit), 0);
        step(1'b0, 4'h0, 4'h0);
        chk("held.no_hit_release", int'(bus.hit), 0);
        step(1'b0, 4'h0, 4'h2);
        chk("held.hit_repress", int'(bus.hit), 1);
        chk("held.score", int'(bus.score), 1);

        // 16 hits saturate the streak, then reset mid-judgement
        do_reset(4'h0);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            nt = 4'($urandom_range(1, 15));
            step(1'b1, nt, 4'h0);
            step(1'b0, 4'h0, 4'h0);
            step(1'b0, 4'h0, 4'h0);
            step(1'b0, 4'h0, nt);
            hits += int'(bus.hit);
            step(1'b0, 4'h0, 4'h0);
        end
        chk("streak16.hits", hits, 16);
        chk("streak16.streak", int'(bus.streak), 15);
        chk("streak16.score", int'(bus.score), 16);
        step(1'b1, 4'h6, 4'h0);
        step(1'b0, 4'h0, 4'h0);
        step(1'b0, 4'h0, 4'h0);
        chk("midreset.active_before", int'(bus.active), 6);
        reset = 1'b1;
        step(1'b0, 4'h0, 4'h0);
        chk_all_zero("midreset.during");
        reset = 1'b0;
        misses = 0;
        hits   = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 4'h0, 4'h0);
            misses += int'(bus.miss);
            hits   += int'(bus.hit);
        end
        chk("midreset.no_miss", misses, 0);
        chk("midreset.no_hit", hits, 0);
        chk("midreset.active_after", int'(bus.active), 0);

        // random traffic, checked cycle by cycle against the model
        pd = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) pd = 4'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            step($urandom_range(0, 3) == 0, 4'($urandom), pd);
        end
        reset = 1'b0;
        step(1'b0, 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
